jk_mod_counter: RTL
===================

Name: jk_mod_counter

Overview:
- Synchronous up/down modulo-N counter whose state register is built from per-bit JK storage cells. Each cell's J/K excitation is derived from the current and desired next state.
- Sits directly downstream of the single-bit JK flip-flop stage. It consumes that cell type as its storage element and produces count, complement and terminal-count outputs for timers and sequencers.
- One clock domain.

Parameters:
- WIDTH, 4, count width in bits (2..16).
- MODULUS, 10, count range 0..MODULUS-1. Constraint: 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- count  output  WIDTH  current count (registered).
- count_bar  output  WIDTH  bitwise complement of count (registered, per-cell Q_bar).
- tc  output  1  terminal count, combinational: en & (up_dn ? count==MODULUS-1 : count==0).
- wrap  output  1  registered one-cycle pulse, high the cycle after a wrap (or saturate) event occurred.

Behaviour:
- Reset is synchronous and active-high: all state changes on the rising edge of clk; reset sampled only at that edge.
- Reset values: count=0, count_bar=all ones, wrap=0. tc follows its equation (0 after reset when up_dn=1 and MODULUS>1).
- Priority per edge: reset > load > en > hold.
- Load:
  - count <= load_val when load_val < MODULUS.
  - Otherwise count <= MODULUS-1 (clamp).
  - wrap <= 0.
  - en is ignored that cycle.
- Count up (en=1, up_dn=1): count==MODULUS-1 -> 0 with wrap<=1; else count+1 with wrap<=0.
- Count down (en=1, up_dn=0): count==0 -> MODULUS-1 with wrap<=1; else count-1 with wrap<=0.
- Hold (en=0, load=0): count unchanged, wrap<=0.
- Arithmetic:
  - next value computed in WIDTH+1 bits and compared against MODULUS before truncation.
  - No out-of-range state is reachable after reset or load.
- Excitation per bit i, with q=current bit and n=next bit: J = ~q & n, K = q & ~n (hold encodes 00). Toggle (11) is never issued.
- Latency: count reflects a step or load one cycle after the triggering edge. wrap is valid in that same cycle.
- Invariant: count_bar == ~count in every cycle, reset included.
- Direction change: up_dn may change any cycle and applies to the current edge. No extra latency.
- Reset asserted mid-count overrides load and en that cycle.

Optional Feature:
- Macro JK_CNT_SATURATE_EN.
- Defined:
  - at MODULUS-1 counting up, or at 0 counting down, count holds instead of wrapping;
  - wrap pulses once on the first saturating step, then stays 0 while held at the bound;
  - tc is unchanged.
- Undefined: modulo wrap-around as described above.

Decomposition:
- Package jk_cnt_pkg holds:
  - localparam-style constants for direction encoding (CNT_UP=1, CNT_DN=0);
  - a typedef for the 2-bit JK command with named values JK_HOLD=00, JK_RESET=01, JK_SET=10, JK_TOGGLE=11.
- Sub-module jk_cnt_cell: one JK storage bit (clk, reset, j, k -> q, q_bar) with synchronous active-high reset to q=0. Instantiated WIDTH times via generate.
- The top level holds next-state, clamp, excitation and wrap logic.

Test Plan:
- Reset, then en=1, up_dn=1 for 12 cycles (WIDTH=4, MODULUS=10) -> count 1..9, 0, 1, 2; wrap high exactly the cycle count becomes 0; tc high while count==9.
- Load with load_val=3, then down-count 5 cycles -> count 3, 2, 1, 0, 9, 8; wrap high when count shows 9.
- load_val=14 with load=1 and en=1 together -> count=9 next cycle (clamp, load wins), wrap=0.
- reset asserted at count=7 with load=1 and en=1 -> count=0, count_bar=4'hF next cycle; held 0 while reset stays high.
- en=0 for 4 cycles at count=5 while toggling up_dn -> count stays 5, wrap=0, tc=0; count_bar==~count checked every cycle.
- With JK_CNT_SATURATE_EN defined: up-count from 8 for 4 cycles -> 9, 9, 9, 9; wrap pulses once only.

Source files
------------

// File: rtl/jk_cnt_pkg.sv
// Shared definitions for the JK-cell modulo counter: count direction encoding
// and the 2-bit J/K excitation command.
package jk_cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_t;

endpackage

// File: rtl/jk_cnt_cell.sv
// One JK storage bit with synchronous active-high reset. q_bar is kept as its
// own register so the complement output comes straight from a flop.
module jk_cnt_cell
    import jk_cnt_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    // NOTE: non-blocking so every cell samples pre-edge state and updates together.
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= 1'b0;
            q_bar <= 1'b1;
        end else begin
            case (jk_cmd_t'({j, k}))
                JK_HOLD: begin
                    q     <= q;
                    q_bar <= q_bar;
                end
                JK_RESET: begin
                    q     <= 1'b0;
                    q_bar <= 1'b1;
                end
                JK_SET: begin
                    q     <= 1'b1;
                    q_bar <= 1'b0;
                end
                JK_TOGGLE: begin
                    q     <= ~q;
                    q_bar <= ~q_bar;
                end
                default: begin
                    q     <= q;
                    q_bar <= q_bar;
                end
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built from JK cells. Define JK_CNT_SATURATE_EN
// to make the count stick at the bound instead of wrapping.
module jk_mod_counter
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             tc,
    output logic             wrap
);

    // MODULUS may equal 2**WIDTH, so range compares are done one bit wider.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH:0]   up_ext;
    logic             at_max;
    logic             at_zero;
    logic             at_bound;
    logic [WIDTH-1:0] next_count;
    logic             wrap_next;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    assign up_ext   = {1'b0, count} + 1'b1;
    assign at_max   = (up_ext == MOD_EXT);
    assign at_zero  = (count == '0);
    assign at_bound = (up_dn == CNT_UP) ? at_max : at_zero;
    assign tc       = en & at_bound;

`ifdef JK_CNT_SATURATE_EN
    // Set while parked at a bound by saturating steps, so wrap fires only once.
    logic sat_held;
    logic sat_held_next;
`endif

    // NOTE: every output gets a default first, so no path leaves a latch behind.
    always_comb begin
        next_count = count;
        wrap_next  = 1'b0;
`ifdef JK_CNT_SATURATE_EN
        sat_held_next = sat_held;
`endif
        if (load) begin
            next_count = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;
`ifdef JK_CNT_SATURATE_EN
            sat_held_next = 1'b0;
`endif
        end else if (en) begin
            if (at_bound) begin
`ifdef JK_CNT_SATURATE_EN
                next_count    = count;
                wrap_next     = ~sat_held;
                sat_held_next = 1'b1;
`else
                next_count = (up_dn == CNT_UP) ? '0 : MAX_VAL;
                wrap_next  = 1'b1;
`endif
            end else begin
                next_count = (up_dn == CNT_UP) ? up_ext[WIDTH-1:0] : count - 1'b1;
`ifdef JK_CNT_SATURATE_EN
                sat_held_next = 1'b0;
`endif
            end
        end
    end

    // Excitation only ever sets or clears a bit; toggle is never issued.
    assign j = ~count & next_count;
    assign k = count & ~next_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cnt_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j[i]),
            .k     (k[i]),
            .q     (count[i]),
            .q_bar (count_bar[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

`ifdef JK_CNT_SATURATE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_held <= 1'b0;
        end else begin
            sat_held <= sat_held_next;
        end
    end
`endif

endmodule
